// File: rtl/alu32_pkg.sv
// Shared constants for the alu32 scheduler: opcodes, FSM encoding, datapath width.
package alu32_pkg;

    localparam int ALU_W = 32;

    localparam logic [2:0] OP_XOR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu32_core.sv
// Combinational 32-bit ALU: xor/add/and/or/not select with illegal-opcode flag.
module alu32_core
    import alu32_pkg::*;
(
    input  logic [2:0]       op,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             ci,
    output logic [ALU_W-1:0] data,
    output logic             co,
    output logic             err
);

    logic [ALU_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + {{ALU_W{1'b0}}, ci};

    always_comb begin
        data = '0;
        co   = 1'b0;
        err  = 1'b0;
        case (op)
            OP_XOR: data = a ^ b;
            OP_ADD: begin
                data = sum[ALU_W-1:0];
                co   = sum[ALU_W];
            end
            OP_AND: data = a & b;
            OP_OR:  data = a | b;
            OP_NOT: data = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu32_sched.sv
// Round-robin scheduler sharing one alu32_core among N_REQ requesters.
// Optional per-requester grant counters when ALU32_SCHED_STATS_EN is defined.
module alu32_sched
    import alu32_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [ALU_W*N_REQ-1:0] req_a,
    input  logic [ALU_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]       req_ci,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]       rsp_data,
    output logic                   rsp_co,
    output logic                   rsp_err,
    output logic                   busy
`ifdef ALU32_SCHED_STATS_EN
    ,
    output logic [16*N_REQ-1:0]    stat_grants
`endif
);

    localparam int IDW = $clog2(N_REQ);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_vld;
    logic             hs;
    logic [2:0]       sel_op;
    logic [ALU_W-1:0] sel_a, sel_b;
    logic             sel_ci;
    logic [IDW-1:0]   id_p0;
    logic [2:0]       op_p0;
    logic [ALU_W-1:0] a_p0, b_p0;
    logic             ci_p0;
    logic [ALU_W-1:0] alu_data, data_p1;
    logic             alu_co, alu_err, co_p1, err_p1;

    // Search starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        int idx;
        grant_id  = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ)
                idx = idx - N_REQ;
            if (!grant_vld && req_valid[IDW'(idx)]) begin
                grant_vld = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        sel_ci = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_op = req_op[3*i +: 3];
                sel_a  = req_a[ALU_W*i +: ALU_W];
                sel_b  = req_b[ALU_W*i +: ALU_W];
                sel_ci = req_ci[i];
            end
        end
    end

    assign hs        = (state == S_IDLE) && grant_vld && !rst;
    assign req_ready = hs ? (N_REQ'(1) << grant_id) : '0;
    assign rsp_valid = (state == S_RESP) ? (N_REQ'(1) << id_p0) : '0;
    assign busy      = (state != S_IDLE);
    assign rsp_data  = data_p1;
    assign rsp_co    = co_p1;
    assign rsp_err   = err_p1;

    // p0: operands captured at the request handshake
    always_ff @(posedge clk) begin
        if (hs) begin
            op_p0 <= sel_op;
            a_p0  <= sel_a;
            b_p0  <= sel_b;
            ci_p0 <= sel_ci;
        end
    end

    alu32_core u_core (
        .op   (op_p0),
        .a    (a_p0),
        .b    (b_p0),
        .ci   (ci_p0),
        .data (alu_data),
        .co   (alu_co),
        .err  (alu_err)
    );

    // p1: ALU result registered in EXEC, held through RESP, cleared on the way back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            id_p0   <= '0;
            data_p1 <= '0;
            co_p1   <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        id_p0 <= grant_id;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    data_p1 <= alu_data;
                    co_p1   <= alu_co;
                    err_p1  <= alu_err;
                    state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[id_p0]) begin
                        ptr     <= (id_p0 == IDW'(N_REQ - 1)) ? '0 : id_p0 + 1'b1;
                        data_p1 <= '0;
                        co_p1   <= 1'b0;
                        err_p1  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU32_SCHED_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] grants [N_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++)
                grants[i] <= '0;
        end else if (hs) begin
            grants[grant_id] <= sat_inc(grants[grant_id]);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_grants[16*g +: 16] = grants[g];
    end
`endif

endmodule

// File: tb/tb_alu32_sched.sv
// Scoreboard bench for alu32_sched (N_REQ = 2); stats checks compile in with ALU32_SCHED_STATS_EN.
module tb_alu32_sched;

    localparam int N = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_ci, rsp_valid, rsp_ready;
    logic [3*N-1:0]  req_op;
    logic [32*N-1:0] req_a, req_b;
    logic [31:0]     rsp_data;
    logic            rsp_co, rsp_err, busy;
`ifdef ALU32_SCHED_STATS_EN
    logic [16*N-1:0] stat_grants;
`endif

    alu32_sched #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_co(rsp_co), .rsp_err(rsp_err), .busy(busy)
`ifdef ALU32_SCHED_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        co;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t model(int id, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic ci);
        exp_t e;
        logic [32:0] s;
        e.id = id; e.data = 32'd0; e.co = 1'b0; e.err = 1'b0;
        case (op)
            3'd0: e.data = a ^ b;
            3'd1: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, ci};
                e.data = s[31:0];
                e.co   = s[32];
            end
            3'd2: e.data = a & b;
            3'd3: e.data = a | b;
            3'd4: e.data = ~a;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic set_req(int id, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic ci);
        req_op[3*id +: 3]  = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_ci[id]         = ci;
    endtask

    // Samples handshakes at the falling edge, pushes accepted requests, returns just after the rising edge.
    task automatic step(output int acc, output int rsp, output logic [31:0] d, output logic co, output logic err);
        @(negedge clk);
        acc = -1;
        rsp = -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc = i;
                sb.push_back(model(i, req_op[3*i +: 3], req_a[32*i +: 32], req_b[32*i +: 32], req_ci[i]));
            end
            if (rsp_valid[i] && rsp_ready[i])
                rsp = i;
        end
        d = rsp_data; co = rsp_co; err = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.id = -1; e.data = 32'hx; e.co = 1'bx; e.err = 1'bx;
        end
    endtask

    task automatic transact(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, output int rid, output logic [31:0] d, output logic co,
                            output logic err, output exp_t e, output bit ok);
        int acc, rsp;
        logic [31:0] dd;
        logic cc, ee;
        set_req(id, op, a, b, ci);
        req_valid[id] = 1'b1;
        ok = 0; rid = -1; d = '0; co = 1'b0; err = 1'b0;
        e.id = -1; e.data = '0; e.co = 1'b0; e.err = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step(acc, rsp, dd, cc, ee);
            if (acc >= 0) req_valid[acc] = 1'b0;
            if (rsp >= 0) begin
                ok = 1; rid = rsp; d = dd; co = cc; err = ee;
                pop_exp(e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = '1;
        set_req(0, 3'd1, 32'h1, 32'h2, 1'b0);
        set_req(1, 3'd0, 32'h3, 32'h4, 1'b0);
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_co, rsp_err, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b vld=%b data=%h co=%b err=%b busy=%b, need all zero",
                     req_ready, rsp_valid, rsp_data, rsp_co, rsp_err, busy);
        end
`ifdef ALU32_SCHED_STATS_EN
        n_checks++;
        if (stat_grants !== '0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h, need 0", stat_grants);
        end
`endif
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_priority();
        int acc, rsp, ids[$];
        logic [31:0] d, datas[$];
        logic co, err;
        exp_t e;
        set_req(0, 3'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
        set_req(1, 3'd3, 32'h1, 32'h2, 1'b0);
        req_valid = '1;
        for (int k = 0; k < 30 && ids.size() < 2; k++) begin
            step(acc, rsp, d, co, err);
            if (acc >= 0) req_valid[acc] = 1'b0;
            if (rsp >= 0) begin
                pop_exp(e);
                n_checks++;
                if (rsp !== e.id || d !== e.data || co !== e.co || err !== e.err) begin
                    n_fail++;
                    $display("FAIL prio_sb: got id=%0d data=%h co=%b err=%b, need id=%0d data=%h co=%b err=%b",
                             rsp, d, co, err, e.id, e.data, e.co, e.err);
                end
                ids.push_back(rsp);
                datas.push_back(d);
            end
        end
        req_valid = '0;
        n_checks++;
        if (ids.size() != 2) begin
            n_fail++;
            $display("FAIL prio_timeout: got %0d responses, need 2", ids.size());
        end else if (ids[0] != 0 || datas[0] !== 32'hFF00FF00 || ids[1] != 1 || datas[1] !== 32'h3) begin
            n_fail++;
            $display("FAIL prio_order: got %0d:%h then %0d:%h, need 0:ff00ff00 then 1:00000003",
                     ids[0], datas[0], ids[1], datas[1]);
        end
    endtask

    task automatic test_add();
        int acc, rsp;
        logic [31:0] d;
        logic co, err;
        exp_t e;
        set_req(0, 3'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL add_req_ready: got %b, need 01", req_ready);
        end
        step(acc, rsp, d, co, err);
        req_valid = '0;
        n_checks++;
        if (acc != 0 || busy !== 1'b1 || rsp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL add_exec: got acc=%0d busy=%b vld=%b, need acc=0 busy=1 vld=00", acc, busy, rsp_valid);
        end
        step(acc, rsp, d, co, err);
        n_checks++;
        if (rsp_valid !== 2'b01 || rsp_data !== 32'h0 || rsp_co !== 1'b1 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL add_t2: got vld=%b data=%h co=%b err=%b, need vld=01 data=00000000 co=1 err=0",
                     rsp_valid, rsp_data, rsp_co, rsp_err);
        end
        step(acc, rsp, d, co, err);
        pop_exp(e);
        n_checks++;
        if (rsp !== e.id || d !== e.data || co !== e.co || err !== e.err) begin
            n_fail++;
            $display("FAIL add_sb: got id=%0d data=%h co=%b, need id=%0d data=%h co=%b", rsp, d, co, e.id, e.data, e.co);
        end
        n_checks++;
        if ({busy, rsp_valid, rsp_data, rsp_co, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL add_idle: got busy=%b vld=%b data=%h co=%b err=%b, need all zero",
                     busy, rsp_valid, rsp_data, rsp_co, rsp_err);
        end
    endtask

    task automatic test_back_to_back();
        int acc, rsp, grants[$], acc_cyc[$], idle_cnt, nrsp, bad;
        logic [31:0] d;
        logic co, err;
        exp_t e;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef ALU32_SCHED_STATS_EN
        n_checks++;
        if (stat_grants !== '0) begin
            n_fail++;
            $display("FAIL b2b_stats_clear: got %h, need 0", stat_grants);
        end
`endif
        set_req(0, 3'd1, 32'h00000100, 32'h00000023, 1'b1);
        set_req(1, 3'd2, 32'hF0F01234, 32'h0FF0FFFF, 1'b0);
        req_valid = '1;
        idle_cnt = 0;
        nrsp = 0;
        for (int cyc = 0; cyc < 60 && nrsp < 6; cyc++) begin
            step(acc, rsp, d, co, err);
            if (acc >= 0) begin
                grants.push_back(acc);
                acc_cyc.push_back(cyc);
                if (grants.size() == 6) req_valid = '0;
            end
            if (rsp >= 0) begin
                nrsp++;
                pop_exp(e);
                n_checks++;
                if (rsp !== e.id || d !== e.data || co !== e.co || err !== e.err) begin
                    n_fail++;
                    $display("FAIL b2b_sb: got id=%0d data=%h co=%b err=%b, need id=%0d data=%h co=%b err=%b",
                             rsp, d, co, err, e.id, e.data, e.co, e.err);
                end
            end
            if (grants.size() >= 1 && grants.size() < 6 && busy === 1'b0) idle_cnt++;
        end
        req_valid = '0;
        bad = 0;
        for (int i = 0; i < grants.size(); i++) begin
            if (grants[i] != i % 2) bad++;
            if (i > 0 && acc_cyc[i] - acc_cyc[i-1] != 3) bad++;
        end
        n_checks++;
        if (nrsp != 6 || grants.size() != 6 || bad != 0) begin
            n_fail++;
            $display("FAIL b2b_grants: got %0d responses, %0d grants, %0d order/interval errors, need 6, 6, 0",
                     nrsp, grants.size(), bad);
        end
        n_checks++;
        if (idle_cnt != 5) begin
            n_fail++;
            $display("FAIL b2b_idle: got %0d idle cycles, need 5", idle_cnt);
        end
`ifdef ALU32_SCHED_STATS_EN
        n_checks++;
        if (stat_grants !== {16'd3, 16'd3}) begin
            n_fail++;
            $display("FAIL b2b_stats: got %h, need 00030003", stat_grants);
        end
`endif
    endtask

    task automatic test_backpressure();
        int acc, rsp, k;
        logic [31:0] d, held;
        logic co, err;
        exp_t e;
        rsp_ready = 2'b01;
        set_req(1, 3'd3, 32'hA5A50000, 32'h00005A5A, 1'b0);
        req_valid = 2'b10;
        for (k = 0; k < 10 && rsp_valid === 2'b00; k++) begin
            step(acc, rsp, d, co, err);
            if (acc >= 0) req_valid[acc] = 1'b0;
        end
        held = rsp_data;
        n_checks++;
        if (rsp_valid !== 2'b10 || held !== 32'hA5A55A5A) begin
            n_fail++;
            $display("FAIL bp_enter: got vld=%b data=%h, need vld=10 data=a5a55a5a", rsp_valid, held);
        end
        set_req(0, 3'd0, 32'h3, 32'h5, 1'b0);
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(acc, rsp, d, co, err);
            n_checks++;
            if (rsp_valid !== 2'b10 || rsp_data !== held || req_ready !== 2'b00 || acc != -1 || rsp != -1) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got vld=%b data=%h ready=%b acc=%0d rsp=%0d, need vld=10 data=%h ready=00",
                         i, rsp_valid, rsp_data, req_ready, acc, rsp, held);
            end
        end
        rsp_ready = '1;
        step(acc, rsp, d, co, err);
        pop_exp(e);
        n_checks++;
        if (rsp != 1 || acc != -1 || d !== e.data || e.id != 1) begin
            n_fail++;
            $display("FAIL bp_release: got rsp=%0d acc=%0d data=%h, need rsp=1 acc=-1 data=%h", rsp, acc, d, e.data);
        end
        rsp = -1;
        for (k = 0; k < 10 && rsp < 0; k++) begin
            step(acc, rsp, d, co, err);
            if (acc >= 0) req_valid[acc] = 1'b0;
        end
        pop_exp(e);
        n_checks++;
        if (rsp != 0 || d !== 32'h6 || e.id != 0 || d !== e.data) begin
            n_fail++;
            $display("FAIL bp_next: got rsp=%0d data=%h, need rsp=0 data=00000006", rsp, d);
        end
    endtask

    task automatic test_illegal_not();
        int rid;
        logic [31:0] d;
        logic co, err;
        exp_t e;
        bit ok;
        transact(0, 3'b110, 32'h12345678, 32'h0000000F, 1'b1, rid, d, co, err, e, ok);
        n_checks++;
        if (!ok || rid != 0 || d !== 32'h0 || co !== 1'b0 || err !== 1'b1 || e.err !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_op: got ok=%0d id=%0d data=%h co=%b err=%b, need id=0 data=0 co=0 err=1",
                     ok, rid, d, co, err);
        end
        transact(1, 3'd4, 32'h0000FFFF, 32'h12340000, 1'b0, rid, d, co, err, e, ok);
        n_checks++;
        if (!ok || rid != 1 || d !== 32'hFFFF0000 || co !== 1'b0 || err !== 1'b0 || d !== e.data) begin
            n_fail++;
            $display("FAIL not_op: got ok=%0d id=%0d data=%h co=%b err=%b, need id=1 data=ffff0000 co=0 err=0",
                     ok, rid, d, co, err);
        end
    endtask

    task automatic test_reset_mid();
        int acc, rsp, stale, rid;
        logic [31:0] d;
        logic co, err;
        exp_t e;
        bit ok;
        set_req(0, 3'd1, 32'h5, 32'h6, 1'b0);
        req_valid = 2'b01;
        step(acc, rsp, d, co, err);
        req_valid = '0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, rsp_valid, rsp_data, rsp_co, rsp_err, req_ready} !== '0 || acc != 0) begin
            n_fail++;
            $display("FAIL rst_exec: got acc=%0d busy=%b vld=%b data=%h, need acc=0 and zero outputs",
                     acc, busy, rsp_valid, rsp_data);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step(acc, rsp, d, co, err);
            if (rsp >= 0 || rsp_valid !== 2'b00 || busy !== 1'b0) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rst_exec_stale: got %0d active cycles, need 0", stale);
        end
        rsp_ready = '0;
        set_req(1, 3'd0, 32'hDEADBEEF, 32'h1, 1'b0);
        req_valid = 2'b10;
        step(acc, rsp, d, co, err);
        req_valid = '0;
        step(acc, rsp, d, co, err);
        n_checks++;
        if (rsp_valid !== 2'b10 || rsp_data !== 32'hDEADBEEE) begin
            n_fail++;
            $display("FAIL rst_resp_pre: got vld=%b data=%h, need vld=10 data=deadbeee", rsp_valid, rsp_data);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, rsp_valid, rsp_data, rsp_co, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL rst_resp: got busy=%b vld=%b data=%h co=%b err=%b, need all zero",
                     busy, rsp_valid, rsp_data, rsp_co, rsp_err);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = '1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step(acc, rsp, d, co, err);
            if (rsp >= 0 || rsp_valid !== 2'b00) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL rst_resp_stale: got %0d response cycles, need 0", stale);
        end
        transact(1, 3'd0, 32'hDEADBEEF, 32'h1, 1'b0, rid, d, co, err, e, ok);
        n_checks++;
        if (!ok || rid != 1 || d !== 32'hDEADBEEE || d !== e.data) begin
            n_fail++;
            $display("FAIL rst_reissue: got ok=%0d id=%0d data=%h, need id=1 data=deadbeee", ok, rid, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; rsp_ready = '1; req_ci = '0;
        req_op = '0; req_a = '0; req_b = '0;
        test_reset();
        test_priority();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_illegal_not();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
